// File: rtl/ad76xx_seq_drive.sv
// ad76xx_seq_drive
// Conversion sequencer for an AD76xx-style simultaneous-sampling ADC that uses
// the parallel read interface. It resets the converter, fires CONVST, waits for
// BUSY, reads CH_NUM words with CS/RD pulses, and presents each word on a
// one-cycle strobe.
//
// Optional feature: when the macro AD_BUSY_TIMEOUT_EN is defined, a stuck BUSY
// is abandoned after BUSY_TIMEOUT cycles. The converter is reset again and the
// sticky o_timeout flag is set. Without the macro, WAIT_BUSY waits forever and
// o_timeout stays 0.
//
// Ports
//   i_clk, i_rst          clock; synchronous active-low reset
//   i_enable, i_mode      run enable; 1 = continuous (SAMPLE_PERIOD), 0 = single-shot
//   i_start               single-shot trigger pulse, honoured only in IDLE
//   o_data/o_chan         captured word and its channel index
//   o_valid/o_last        word strobe; o_last marks channel CH_NUM-1
//   o_overrun             pulse when a periodic trigger falls inside a frame
//   o_timeout             sticky BUSY timeout flag
//   o_ad_*                ADC control pins (registered)
//   i_ad_busy, i_ad_data  ADC BUSY and parallel data bus
//   o_dbg_state           current FSM state encoding
//
// Output handshake: o_valid is a single-cycle strobe with no backpressure. The
// o_data, o_chan and o_last values are meaningful only in the cycle o_valid is
// 1. A consumer must take the word in that cycle.
module ad76xx_seq_drive #(
  parameter int unsigned CH_NUM        = 8,
  parameter int unsigned DATA_W        = 16,
  parameter logic [2:0]  OS_RATIO      = 3'b000,
  parameter logic        RANGE_SEL     = 1'b0,
  parameter int unsigned SAMPLE_PERIOD = 2000,
  parameter int unsigned RESET_CYC     = 10,
  parameter int unsigned CONV_LOW_CYC  = 2,
  parameter int unsigned RD_LOW_CYC    = 2,
  parameter int unsigned RD_HIGH_CYC   = 2,
  parameter int unsigned BUSY_TIMEOUT  = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_mode,
  input  logic              i_start,
  output logic [DATA_W-1:0] o_data,
  output logic [2:0]        o_chan,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_overrun,
  output logic              o_timeout,
  output logic              o_ad_psb_sel,
  output logic              o_ad_stby,
  output logic              o_ad_convstA,
  output logic              o_ad_convstB,
  output logic              o_ad_reset,
  output logic              o_ad_cs,
  output logic              o_ad_rd,
  output logic [2:0]        o_ad_osc,
  output logic              o_ad_range,
  input  logic              i_ad_busy,
  input  logic [DATA_W-1:0] i_ad_data,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    ST_RST_ADC   = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CONV      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_READ_LO   = 3'd4,
    ST_READ_HI   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // One shared phase counter serves every timed state, so size it for the longest.
  localparam int unsigned MAX_A   = (RESET_CYC > BUSY_TIMEOUT) ? RESET_CYC : BUSY_TIMEOUT;
  localparam int unsigned MAX_B   = (CONV_LOW_CYC > RD_LOW_CYC) ? CONV_LOW_CYC : RD_LOW_CYC;
  localparam int unsigned MAX_C   = (MAX_B > RD_HIGH_CYC) ? MAX_B : RD_HIGH_CYC;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PER_W   = $clog2(SAMPLE_PERIOD + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
  logic [2:0]         rd_chan_q, rd_chan_d;
  logic               busy_q, busy_d;
  logic               seen_q, seen_d;
  logic               mode_q, mode_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [2:0]         chan_q, chan_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               cs_q, cs_d;
  logic               rd_q, rd_d;
  logic               conv_q, conv_d;
  logic               ad_reset_q, ad_reset_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_cnt_d  = per_cnt_q;
    rd_chan_d  = rd_chan_q;
    busy_d     = i_ad_busy;
    seen_d     = seen_q;
    mode_d     = mode_q;
    data_d     = data_q;
    chan_d     = chan_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    overrun_d  = 1'b0;
    timeout_d  = timeout_q;
    cs_d       = cs_q;
    rd_d       = rd_q;
    conv_d     = conv_q;

    // The period counter counts down from each CONV entry and rests at 0, which
    // means "expired". If it expires while a continuous frame is still running,
    // that trigger is dropped and the count restarts. Frames are never queued.
    if (per_cnt_q != '0) begin
      per_cnt_d = per_cnt_q - 1'b1;
    end else if (state_q != ST_IDLE && state_q != ST_RST_ADC && mode_q && i_enable) begin
      overrun_d = 1'b1;
      per_cnt_d = PER_W'(SAMPLE_PERIOD - 1);
    end

    case (state_q)
      ST_RST_ADC: begin
        if (cnt_q == CNT_W'(RESET_CYC)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_enable && ((i_mode && per_cnt_q == '0) || (!i_mode && i_start))) begin
          state_d   = ST_CONV;
          cnt_d     = '0;
          conv_d    = 1'b0;
          mode_d    = i_mode;
          per_cnt_d = PER_W'(SAMPLE_PERIOD - 1);
        end
      end
      ST_CONV: begin
        if (cnt_q == CNT_W'(CONV_LOW_CYC - 1)) begin
          state_d = ST_WAIT_BUSY;
          cnt_d   = '0;
          conv_d  = 1'b1;
          seen_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        // BUSY must be seen high once before its fall counts as end of conversion.
        // This keeps a stale low value from the CONVST edge from being misread.
        if (seen_q && !busy_q) begin
          state_d   = ST_READ_LO;
          cnt_d     = '0;
          cs_d      = 1'b0;
          rd_d      = 1'b0;
          rd_chan_d = '0;
        end
`ifdef AD_BUSY_TIMEOUT_EN
        else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_RST_ADC;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (busy_q) seen_d = 1'b1;
        end
`else
        else if (busy_q) begin
          seen_d = 1'b1;
        end
`endif
      end
      ST_READ_LO: begin
        if (cnt_q == CNT_W'(RD_LOW_CYC - 1)) begin
          // Last low cycle: the bus has settled, so take the word now.
          data_d  = i_ad_data;
          chan_d  = rd_chan_q;
          last_d  = (rd_chan_q == 3'(CH_NUM - 1));
          valid_d = 1'b1;
          state_d = ST_READ_HI;
          rd_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ_HI: begin
        if (cnt_q == CNT_W'(RD_HIGH_CYC - 1)) begin
          cnt_d = '0;
          if (rd_chan_q == 3'(CH_NUM - 1)) begin
            state_d = ST_DONE;
            cs_d    = 1'b1;
          end else begin
            state_d   = ST_READ_LO;
            rd_d      = 1'b0;
            rd_chan_d = rd_chan_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_RST_ADC;
        cnt_d   = '0;
      end
    endcase

    // RESET is high only while RST_ADC is held. The state's entry cycle is low,
    // so the pulse is exactly RESET_CYC wide, both after i_rst and after a timeout.
    ad_reset_d = (state_q == ST_RST_ADC) && (state_d == ST_RST_ADC);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_RST_ADC;
      cnt_q      <= '0;
      per_cnt_q  <= '0;
      rd_chan_q  <= '0;
      busy_q     <= 1'b0;
      seen_q     <= 1'b0;
      mode_q     <= 1'b0;
      data_q     <= '0;
      chan_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cs_q       <= 1'b1;
      rd_q       <= 1'b1;
      conv_q     <= 1'b1;
      ad_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_cnt_q  <= per_cnt_d;
      rd_chan_q  <= rd_chan_d;
      busy_q     <= busy_d;
      seen_q     <= seen_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      chan_q     <= chan_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      conv_q     <= conv_d;
      ad_reset_q <= ad_reset_d;
    end
  end

  assign o_data       = data_q;
  assign o_chan       = chan_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;
  assign o_ad_psb_sel = 1'b0;
  assign o_ad_stby    = 1'b1;
  assign o_ad_convstA = conv_q;
  assign o_ad_convstB = conv_q;
  assign o_ad_reset   = ad_reset_q;
  assign o_ad_cs      = cs_q;
  assign o_ad_rd      = rd_q;
  assign o_ad_osc     = OS_RATIO;
  assign o_ad_range   = RANGE_SEL;
  assign o_dbg_state  = state_q;

endmodule

// File: doc/ad76xx_seq_drive.md
AD76XX_SEQ_DRIVE -- requirements
Module: ad76xx_seq_drive

Interface
REQ-001 Parameter CH_NUM, default 8, number of channels read per frame (1..8).
REQ-002 Parameter DATA_W, default 16, ADC word width (16 or 18).
REQ-003 Parameter OS_RATIO, default 3'b000, value driven on o_ad_osc.
REQ-004 Parameter RANGE_SEL, default 1'b0, value driven on o_ad_range.
REQ-005 Parameter SAMPLE_PERIOD, default 2000, clk cycles between conversion starts in continuous mode.
REQ-006 Parameters RESET_CYC/CONV_LOW_CYC/RD_LOW_CYC/RD_HIGH_CYC, defaults 10/2/2/2, pulse widths in clk cycles (each >=1).
REQ-007 Parameter BUSY_TIMEOUT, default 4096, max clk cycles spent in WAIT_BUSY.
REQ-008 i_clk  in  1  system clock; one clock domain only.
REQ-009 i_rst  in  1  reset, synchronous, active-low.
REQ-010 i_enable  in  1  user run enable.
REQ-011 i_mode  in  1  1 = continuous sampling, 0 = single-shot.
REQ-012 i_start  in  1  single-shot trigger, one-cycle pulse.
REQ-013 o_data  out  DATA_W  sampled channel word.
REQ-014 o_chan  out  3  channel index of o_data.
REQ-015 o_valid / o_last  out  1/1  word strobe; last word of frame.
REQ-016 o_overrun  out  1  one-cycle pulse, trigger dropped.
REQ-017 o_timeout  out  1  sticky busy-timeout flag (macro-dependent).
REQ-018 o_ad_psb_sel, o_ad_stby, o_ad_convstA, o_ad_convstB, o_ad_reset, o_ad_cs, o_ad_rd  out  1 each  ADC control.
REQ-019 o_ad_osc  out  3; o_ad_range  out  1; i_ad_busy  in  1; i_ad_data  in  DATA_W.

Function
REQ-020 States: RST_ADC, IDLE, CONV, WAIT_BUSY, READ_LO, READ_HI, DONE.
REQ-021 RST_ADC: o_ad_reset=1 for RESET_CYC cycles, then IDLE.
REQ-022 IDLE->CONV when i_enable=1 and (i_mode=1 and period counter expired, or i_mode=0 and i_start=1).
REQ-023 CONV: convstA/B both 0 for CONV_LOW_CYC cycles, then 1; -> WAIT_BUSY.
REQ-024 WAIT_BUSY: register busy; require one cycle busy=1, then first busy=0 -> READ_LO with o_ad_cs=0.
REQ-025 READ_LO: o_ad_rd=0 for RD_LOW_CYC cycles; i_ad_data captured on last low cycle; READ_HI: o_ad_rd=1 for RD_HIGH_CYC cycles.
REQ-026 o_valid=1 for exactly one cycle, the cycle after capture; o_chan=0..CH_NUM-1 ascending; o_last=1 with chan CH_NUM-1.
REQ-027 After READ_HI of channel CH_NUM-1 -> DONE: o_ad_cs=1 one cycle, -> IDLE.
REQ-028 Period counter runs from each CONV entry; expiry while not IDLE: trigger dropped, o_overrun pulses, counter restarts.
REQ-029 i_start outside IDLE or with i_mode=1 ignored; no queuing.
REQ-030 i_enable falling mid-frame: current frame completes, then IDLE.
REQ-031 i_mode change takes effect only in IDLE.
REQ-032 Static outputs: o_ad_psb_sel=0 (parallel), o_ad_stby=1, o_ad_osc=OS_RATIO, o_ad_range=RANGE_SEL.

Reset
REQ-033 i_rst=0 at a clk edge: state->RST_ADC, counters 0, o_data=0, o_chan=0, o_valid=0, o_last=0, o_overrun=0, o_timeout=0, o_ad_cs=1, o_ad_rd=1, convstA/B=1, o_ad_reset=0.
REQ-034 Reset mid-frame aborts without emitting remaining words; RST_ADC sequence restarts after release.

Configuration
REQ-035 Macro AD_BUSY_TIMEOUT_EN defined: WAIT_BUSY exceeding BUSY_TIMEOUT cycles sets o_timeout=1 (sticky until reset), -> RST_ADC, no words emitted.
REQ-036 Macro undefined: WAIT_BUSY waits indefinitely; o_timeout tied 0.

Verification
REQ-037 Continuous, CH_NUM=8, busy model 1 for 50 cycles after convst rise, data=16'h5555 -> 8 valids, chan 0..7, o_last on chan 7, convst starts 2000 cycles apart.
REQ-038 Single-shot, i_start once -> exactly one 8-word frame; second i_start during READ ignored.
REQ-039 CH_NUM=4, DATA_W=18, data=18'h2AAAA -> 4 words per frame, o_last on chan 3.
REQ-040 i_ad_busy stuck 1, AD_BUSY_TIMEOUT_EN defined -> o_timeout=1 after 4096 cycles, RST_ADC re-entered, no valids; undefined -> hang in WAIT_BUSY.
REQ-041 SAMPLE_PERIOD=20 with frame longer than 20 cycles -> o_overrun pulses, no overlapping frames.
REQ-042 i_rst=0 during READ_LO of chan 3 -> next cycle cs=1, rd=1, valid=0; after release o_ad_reset high 10 cycles.
